// File: rtl/encrypt_round_sequencer_if.sv
// Byte-in / ciphertext-out handshake bundle for the round sequencer.
interface encrypt_round_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] number;
  logic [7:0] key;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] enc_number;

  modport slave (input in_valid, number, key, out_ready,
                 output in_ready, out_valid, enc_number);
  modport master(output in_valid, number, key, out_ready,
                 input in_ready, out_valid, enc_number);
endinterface

// File: rtl/encrypt_round_sequencer.sv
// Sequenced 8-bit round engine: capture in IDLE, one round per clock, hold the
// ciphertext in DONE until the sink takes it.
module encrypt_round_sequencer #(
  parameter int NUM_ROUNDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  encrypt_round_sequencer_if.slave   bus,
  input  logic                       abort,
  output logic                       busy,
  output logic [3:0]                 round_idx
);
  generate
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_rounds
      $error("NUM_ROUNDS out of range 1..15");
    end
  endgenerate

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} st_t;

  st_t        st, st_nxt;
  logic [7:0] state_reg, key_reg;
  logic [3:0] rcnt;
  logic       last;

  assign last = (rcnt == LAST);

  function automatic logic [7:0] rnd(input logic [7:0] s, input logic [7:0] k);
    return {s[3:0] ^ {3'b000, s[3] ^ k[3]}, k[3:0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;

  // abort outranks both handshakes, so it is checked before any transfer
  always_comb begin
    st_nxt = st;
    if (abort) st_nxt = IDLE;
    else begin
      case (st)
        IDLE:    if (bus.in_valid)  st_nxt = ROUND;
        ROUND:   if (last)          st_nxt = DONE;
        DONE:    if (bus.out_ready) st_nxt = IDLE;
        default:                    st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_reg <= '0;
      key_reg   <= '0;
      rcnt      <= '0;
    end else if (abort) begin
      rcnt <= '0;
    end else begin
      case (st)
        IDLE: if (bus.in_valid) begin
          state_reg <= bus.number;
          key_reg   <= bus.key;
          rcnt      <= '0;
        end
        ROUND: begin
          state_reg <= rnd(state_reg, key_reg);
          key_reg   <= {key_reg[6:0], key_reg[7]};
          rcnt      <= last ? 4'd0 : rcnt + 4'd1;
        end
        default: rcnt <= '0;
      endcase
    end

  always_comb begin
    bus.in_ready   = (st == IDLE);
    bus.out_valid  = (st == DONE);
    bus.enc_number = state_reg;
    busy           = (st == ROUND) || (st == DONE);
    round_idx      = (st == ROUND) ? rcnt : 4'd0;
  end
endmodule

// File: tb/tb_encrypt_round_sequencer.sv
// Bench for encrypt_round_sequencer: block-level model for a 4-round engine plus
// directed checks on a 1-round engine.
module tb_encrypt_round_sequencer;
  logic clk = 0;
  logic rst_n;
  logic abort4, abort1;
  logic busy4, busy1;
  logic [3:0] ri4, ri1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  encrypt_round_sequencer_if b4();
  encrypt_round_sequencer_if b1();

  encrypt_round_sequencer #(.NUM_ROUNDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4), .abort(abort4), .busy(busy4), .round_idx(ri4));
  encrypt_round_sequencer #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .abort(abort1), .busy(busy1), .round_idx(ri1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] cipher(input logic [7:0] s, input logic [7:0] k, input int n);
    logic [7:0] x = s, y = k;
    for (int r = 0; r < n; r++) begin
      x = {x[3:0] ^ {3'b000, x[3] ^ y[3]}, y[3:0]};
      y = {y[6:0], y[7]};
    end
    return x;
  endfunction

  // Block-level view of the 4-round engine: idle, or m_cnt edges into a block
  // (0..3 rounds done, 4 = result waiting).
  bit         m_idle;
  int         m_cnt;
  logic [7:0] m_exp;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_idle <= 1; m_cnt <= 0; m_exp <= 8'h00;
    end else if (abort4) begin
      m_idle <= 1; m_cnt <= 0;
    end else if (m_idle) begin
      if (b4.in_valid) begin
        m_idle <= 0; m_cnt <= 0; m_exp <= cipher(b4.number, b4.key, 4);
      end
    end else if (m_cnt < 4) m_cnt <= m_cnt + 1;
    else if (b4.out_ready) m_idle <= 1;

  always @(negedge clk) begin
    chk("m_in_ready", b4.in_ready, m_idle);
    chk("m_busy", busy4, !m_idle);
    chk("m_out_valid", b4.out_valid, !m_idle && m_cnt == 4);
    chk("m_round_idx", ri4, (!m_idle && m_cnt < 4) ? m_cnt : 0);
    if (b4.out_valid) chk("m_enc", b4.enc_number, m_exp);
  end

  task automatic reset_vals(input string tag);
    chk({tag, "_in_ready4"}, b4.in_ready, 1);
    chk({tag, "_out_valid4"}, b4.out_valid, 0);
    chk({tag, "_enc4"}, b4.enc_number, 8'h00);
    chk({tag, "_busy4"}, busy4, 0);
    chk({tag, "_ridx4"}, ri4, 0);
    chk({tag, "_in_ready1"}, b1.in_ready, 1);
    chk({tag, "_out_valid1"}, b1.out_valid, 0);
    chk({tag, "_enc1"}, b1.enc_number, 8'h00);
  endtask

  // Launch a block on the 4-round engine and wait for its result.
  task automatic run4(input logic [7:0] n, input logic [7:0] k, output int edges,
                      output logic [15:0] ridx_seq);
    b4.number = n; b4.key = k; b4.in_valid = 1;
    @(posedge clk); edges = 1; #1;
    b4.in_valid = 0;
    ridx_seq = 16'h0;
    while (!b4.out_valid && edges < 20) begin
      ridx_seq = {ridx_seq[11:0], ri4};
      @(posedge clk); edges++; #1;
    end
  endtask

  initial begin
    int edges, rises;
    logic [15:0] seq;
    rst_n = 0; abort4 = 0; abort1 = 0;
    b4.in_valid = 0; b4.number = 0; b4.key = 0; b4.out_ready = 1;
    b1.in_valid = 0; b1.number = 0; b1.key = 0; b1.out_ready = 1;
    #1 reset_vals("rst0");

    chk("model_r1", cipher(8'h46, 8'h93, 1), 8'h63);
    chk("model_r2", cipher(8'h46, 8'h93, 2), 8'h37);
    chk("model_r3", cipher(8'h46, 8'h93, 3), 8'h6E);
    chk("model_r4", cipher(8'h46, 8'h93, 4), 8'hEC);

    #11 rst_n = 1;
    @(posedge clk); #1;

    // basic block, out_ready high
    run4(8'h46, 8'h93, edges, seq);
    chk("lat4", edges, 5);
    chk("enc4", b4.enc_number, 8'hEC);
    chk("ridx_seq", seq, 16'h0123);
    @(posedge clk); #1;
    chk("idle_after_handoff", b4.in_ready, 1);

    // single-round engine
    b1.number = 8'h46; b1.key = 8'h93; b1.in_valid = 1;
    @(posedge clk); edges = 1; #1;
    b1.in_valid = 0;
    chk("ridx1_round", ri1, 0);
    chk("busy1_round", busy1, 1);
    while (!b1.out_valid && edges < 20) begin @(posedge clk); edges++; #1; end
    chk("lat1", edges, 2);
    chk("enc1", b1.enc_number, 8'h63);
    @(posedge clk); #1;
    chk("idle1", b1.in_ready, 1);

    // back-pressure in DONE, with junk on the input side
    b4.out_ready = 0;
    run4(8'h46, 8'h93, edges, seq);
    chk("lat_bp", edges, 5);
    for (int i = 0; i < 10; i++) begin
      b4.in_valid = i[0]; b4.number = 8'($urandom); b4.key = 8'($urandom);
      @(posedge clk); #1;
      chk("bp_enc", b4.enc_number, 8'hEC);
      chk("bp_in_ready", b4.in_ready, 0);
      chk("bp_out_valid", b4.out_valid, 1);
    end
    b4.in_valid = 0; b4.out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release", b4.in_ready, 1);

    // abort during round 2 together with a would-be capture
    b4.number = 8'h46; b4.key = 8'h93; b4.in_valid = 1;
    @(posedge clk); #1;
    b4.in_valid = 0;
    edges = 0;
    while (ri4 != 4'd2 && edges < 10) begin @(posedge clk); edges++; #1; end
    chk("reach_round2", ri4, 2);
    abort4 = 1; b4.in_valid = 1; b4.number = 8'h11; b4.key = 8'h22;
    @(posedge clk); #1;
    abort4 = 0; b4.in_valid = 0;
    chk("abort_idle", b4.in_ready, 1);
    chk("abort_busy", busy4, 0);
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (b4.out_valid) rises++;
    end
    chk("abort_no_out", rises, 0);
    run4(8'h46, 8'h93, edges, seq);
    chk("post_abort_lat", edges, 5);
    chk("post_abort_enc", b4.enc_number, 8'hEC);
    @(posedge clk); #1;

    // reset mid-ROUND
    b4.number = 8'hA5; b4.key = 8'h3C; b4.in_valid = 1;
    @(posedge clk); #1;
    b4.in_valid = 0;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy4, 1);
    #2 rst_n = 0;
    #1 reset_vals("rst_mid");
    #3 rst_n = 1;
    @(posedge clk); #1;
    reset_vals("rst_rel");
    run4(8'h46, 8'h93, edges, seq);
    chk("post_rst_lat", edges, 5);
    chk("post_rst_enc", b4.enc_number, 8'hEC);
    @(posedge clk); #1;
    chk("post_rst_idle", b4.in_ready, 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
